// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame FSM states and mode constants.
// Used by both the master transmitter and the slave receiver.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        TRANSFER,
        CS_HOLD,
        GAP
    } spi_state_t;

    localparam logic SPI_CPOL      = 1'b0;
    localparam logic SPI_CPHA      = 1'b0;
    localparam int   SPI_BYTE_W    = 8;
    localparam logic SPI_MSB_FIRST = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_tx_if.sv
// Producer handshake plus SPI pin bundle of the master transmitter.
// master modport is the transmitter's view, slave modport the producer/line side.
interface spi_master_tx_if;
    logic                          tx_dv;
    logic [spi_pkg::SPI_BYTE_W-1:0] tx_byte;
    logic                          tx_ready;
    logic                          tx_done;
    logic                          cs;
    logic                          s_clk;
    logic                          mosi;

    modport master (
        input  tx_dv, tx_byte,
        output tx_ready, tx_done, cs, s_clk, mosi
    );

    modport slave (
        output tx_dv, tx_byte,
        input  tx_ready, tx_done, cs, s_clk, mosi
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// Half-bit counter producing the SCLK level and one-cycle rise/fall strobes.
// Strobes flag the edge at which sclk toggles; held idle while en is low.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise,
    output logic fall,
    output logic sclk
);
    localparam int HW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam logic [HW-1:0] H_LAST = HW'(CLKS_PER_HALF_BIT - 1);

    logic [HW-1:0] half_cnt;
    logic          level;
    logic          wrap;

    assign wrap = en && (half_cnt == H_LAST);
    assign rise = wrap && (level == SPI_CPOL);
    assign fall = wrap && (level != SPI_CPOL);
    assign sclk = level;

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            half_cnt <= '0;
            level    <= SPI_CPOL;
        end else if (wrap) begin
            half_cnt <= '0;
            level    <= ~level;
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end
endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 SPI byte transmitter: one byte per CS frame, MSB first, registered outputs.
// Accept-to-CS-low is one cycle; new bytes are refused (ready low) until the inter-frame gap ends.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLKS_PER_HALF_BIT = 2,
    parameter int CS_SETUP_CLKS     = 1,
    parameter int CS_HOLD_CLKS      = 1,
    parameter int INTER_BYTE_CLKS   = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    spi_master_tx_if.master bus
);
    localparam int MAXP = max4(CLKS_PER_HALF_BIT, CS_SETUP_CLKS, CS_HOLD_CLKS, INTER_BYTE_CLKS);
    localparam int CW   = $clog2(MAXP + 1);
    localparam logic [CW-1:0] S_LAST = CW'(CS_SETUP_CLKS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CS_HOLD_CLKS - 1);
    localparam logic [CW-1:0] G_LAST = CW'(INTER_BYTE_CLKS - 1);

    spi_state_t            state;
    logic [CW-1:0]         cnt;
    logic [SPI_BYTE_W-1:0] shreg;
    logic [2:0]            bit_cnt;
    logic                  last_bit;
    logic                  cs_q, mosi_q, ready_q, done_q;
    logic                  sclk_en, rise, fall, sclk;

    assign sclk_en = (state == TRANSFER);

    spi_sclk_gen #(.CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)) u_sclk_gen (
        .clk  (i_clk),
        .rst  (i_rst),
        .en   (sclk_en),
        .rise (rise),
        .fall (fall),
        .sclk (sclk)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            last_bit <= 1'b0;
            cs_q     <= 1'b1;
            mosi_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tx_dv) begin
                        shreg    <= bus.tx_byte;
                        mosi_q   <= bus.tx_byte[SPI_BYTE_W-1];
                        bit_cnt  <= 3'd7;
                        last_bit <= 1'b0;
                        cnt      <= '0;
                        cs_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        state    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == S_LAST) begin
                        cnt   <= '0;
                        state <= TRANSFER;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                TRANSFER: begin
                    // bit_cnt reaches 0 on the 7th rise; the 8th rise marks the final bit
                    if (rise) begin
                        if (bit_cnt == 3'd0) last_bit <= 1'b1;
                        else                 bit_cnt  <= bit_cnt - 3'd1;
                    end
                    if (fall) begin
                        if (last_bit) begin
                            last_bit <= 1'b0;
                            state    <= CS_HOLD;
                        end else begin
                            mosi_q <= shreg[SPI_BYTE_W-2];
                            shreg  <= {shreg[SPI_BYTE_W-2:0], 1'b0};
                        end
                    end
                end
                CS_HOLD: begin
                    if (cnt == C_LAST) begin
                        cnt    <= '0;
                        cs_q   <= 1'b1;
                        mosi_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= GAP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt == G_LAST) begin
                        cnt     <= '0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx_ready = ready_q;
    assign bus.tx_done  = done_q;
    assign bus.cs       = cs_q;
    assign bus.s_clk    = sclk;
    assign bus.mosi     = mosi_q;
endmodule
